// File: rtl/exec_pkg.sv
// Shared definitions for the RV32 execute stage: ALU opcodes and default datapath width.
package exec_pkg;
  localparam int DATA_W = 32;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;
  localparam logic [3:0] ALU_MUL   = 4'd11;
endpackage

// File: rtl/exec_unit_alu_core.sv
// Purely combinational RV32 ALU. Define EXEC_MUL_EN to give ALU_MUL a real
// (low-half, unsigned) multiplier; otherwise that opcode returns 0.
module alu_core
  import exec_pkg::*;
#(
  parameter int W = exec_pkg::DATA_W
) (
  input  logic [3:0]   sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  localparam int SH_W = $clog2(W);

  logic [SH_W-1:0] sh;
  logic            lt_s, lt_u;

  assign sh   = b[SH_W-1:0];
  assign lt_s = $signed(a) < $signed(b);
  assign lt_u = a < b;

  always_comb begin
    y = '0;
    case (sel)
      ALU_ADD:   y = a + b;
      ALU_SUB:   y = a - b;
      ALU_SLL:   y = a << sh;
      ALU_SLT:   y = {{(W-1){1'b0}}, lt_s};
      ALU_SLTU:  y = {{(W-1){1'b0}}, lt_u};
      ALU_XOR:   y = a ^ b;
      ALU_SRL:   y = a >> sh;
      ALU_SRA:   y = $unsigned($signed(a) >>> sh);
      ALU_OR:    y = a | b;
      ALU_AND:   y = a & b;
      ALU_PASSB: y = b;
`ifdef EXEC_MUL_EN
      ALU_MUL:   y = a * b;
`else
      ALU_MUL:   y = '0;
`endif
      default:   y = '0;
    endcase
  end
endmodule

// File: rtl/exec_unit.sv
// Registered execute stage: free adder, ALU and branch comparator captured in one
// output register. Optional multiplier enabled by EXEC_MUL_EN (see alu_core).
module exec_unit
  import exec_pkg::*;
#(
  parameter int DATA_W = exec_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] add_in0,
  input  logic [DATA_W-1:0] add_in1,
  input  logic [3:0]        alu_sel,
  input  logic [DATA_W-1:0] rs1,
  input  logic [DATA_W-1:0] rs2,
  input  logic              br_un,
  output logic              out_valid,
  output logic [DATA_W-1:0] adder_out,
  output logic [DATA_W-1:0] alu_out,
  output logic              br_eq,
  output logic              br_lt
);
  logic [DATA_W-1:0] add_d, alu_d;
  logic              eq_d, lt_d;

  assign add_d = add_in0 + add_in1;
  assign eq_d  = rs1 == rs2;
  assign lt_d  = br_un ? (rs1 < rs2) : ($signed(rs1) < $signed(rs2));

  alu_core #(.W(DATA_W)) u_alu (
    .sel (alu_sel),
    .a   (rs1),
    .b   (rs2),
    .y   (alu_d)
  );

  // Data outputs only advance on valid input; out_valid tracks in_valid every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      adder_out <= '0;
      alu_out   <= '0;
      br_eq     <= 1'b0;
      br_lt     <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        adder_out <= add_d;
        alu_out   <= alu_d;
        br_eq     <= eq_d;
        br_lt     <= lt_d;
      end
    end
  end
endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit; expectations are hand-computed constants.
module tb_exec_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] add_in0 = '0, add_in1 = '0, rs1 = '0, rs2 = '0;
  logic [3:0]  alu_sel = '0;
  logic        br_un = 1'b0;
  logic        out_valid, br_eq, br_lt;
  logic [31:0] adder_out, alu_out;

  int n_assert = 0;
  int n_fail   = 0;

  exec_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .add_in0(add_in0), .add_in1(add_in1), .alu_sel(alu_sel),
    .rs1(rs1), .rs2(rs2), .br_un(br_un),
    .out_valid(out_valid), .adder_out(adder_out), .alu_out(alu_out),
    .br_eq(br_eq), .br_lt(br_lt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                      input logic un);
    in_valid = v; alu_sel = sel; rs1 = a; rs2 = b; br_un = un;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] mul_exp;
`ifdef EXEC_MUL_EN
    mul_exp = 32'd42;
`else
    mul_exp = 32'd0;
`endif
    #2;
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_adder", adder_out, 32'd0);
    check("rst_alu", alu_out, 32'd0);
    check("rst_br", {30'b0, br_eq, br_lt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    add_in0 = 32'd4; add_in1 = 32'd5;
    step(1'b1, 4'd0, 32'd525, 32'd273, 1'b0);
    check("add_valid", {31'b0, out_valid}, 32'd1);
    check("adder_4p5", adder_out, 32'd9);
    check("alu_add", alu_out, 32'd798);
    check("br_gt_eq", {31'b0, br_eq}, 32'd0);
    check("br_gt_lt", {31'b0, br_lt}, 32'd0);

    step(1'b1, 4'd1, 32'd525, 32'd273, 1'b0);
    check("alu_sub", alu_out, 32'd252);

    step(1'b1, 4'd1, 32'd0, 32'd1, 1'b0);
    check("alu_sub_wrap", alu_out, 32'hFFFF_FFFF);

    step(1'b1, 4'd0, 32'd1, 32'd1, 1'b0);
    check("br_equal_eq", {31'b0, br_eq}, 32'd1);
    check("br_equal_lt", {31'b0, br_lt}, 32'd0);
    check("alu_add_1p1", alu_out, 32'd2);

    add_in0 = 32'hFFFF_FFFF; add_in1 = 32'd2;
    step(1'b1, 4'd3, 32'hFFFF_FFFF, 32'd1, 1'b0);
    check("adder_wrap", adder_out, 32'd1);
    check("br_signed_lt", {31'b0, br_lt}, 32'd1);
    check("br_signed_eq", {31'b0, br_eq}, 32'd0);
    check("alu_slt", alu_out, 32'd1);

    step(1'b1, 4'd4, 32'hFFFF_FFFF, 32'd1, 1'b1);
    check("br_unsigned_lt", {31'b0, br_lt}, 32'd0);
    check("alu_sltu", alu_out, 32'd0);

    step(1'b1, 4'd7, 32'h8000_0000, 32'd4, 1'b0);
    check("alu_sra", alu_out, 32'hF800_0000);
    step(1'b1, 4'd6, 32'h8000_0000, 32'd4, 1'b0);
    check("alu_srl", alu_out, 32'h0800_0000);
    step(1'b1, 4'd2, 32'd1, 32'h0000_0024, 1'b0);
    check("alu_sll_shmask", alu_out, 32'h0000_0010);
    step(1'b1, 4'd5, 32'hF0F0_1234, 32'h0FF0_1200, 1'b0);
    check("alu_xor", alu_out, 32'hFF00_0034);
    step(1'b1, 4'd8, 32'hF0F0_0000, 32'h0F00_00AA, 1'b0);
    check("alu_or", alu_out, 32'hFFF0_00AA);
    step(1'b1, 4'd9, 32'hF0F0_FFFF, 32'h0FF0_00AA, 1'b0);
    check("alu_and", alu_out, 32'h00F0_00AA);
    step(1'b1, 4'd10, 32'h1234_5678, 32'hABCD_E000, 1'b0);
    check("alu_passb", alu_out, 32'hABCD_E000);
    step(1'b1, 4'd13, 32'h1234_5678, 32'hABCD_E000, 1'b0);
    check("alu_undef13", alu_out, 32'd0);

    step(1'b1, 4'd11, 32'd6, 32'd7, 1'b0);
    check("alu_mul", alu_out, mul_exp);
    check("mul_br_lt", {31'b0, br_lt}, 32'd1);

    add_in0 = 32'd100; add_in1 = 32'd1;
    step(1'b0, 4'd0, 32'd3, 32'd3, 1'b0);
    check("hold_valid", {31'b0, out_valid}, 32'd0);
    check("hold_alu", alu_out, mul_exp);
    check("hold_adder", adder_out, 32'd1);
    check("hold_br", {30'b0, br_eq, br_lt}, 32'd1);

    step(1'b1, 4'd0, 32'd10, 32'd20, 1'b0);
    check("resume_alu", alu_out, 32'd30);
    check("resume_adder", adder_out, 32'd101);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_adder", adder_out, 32'd0);
    check("midrst_alu", alu_out, 32'd0);
    check("midrst_br", {30'b0, br_eq, br_lt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 4'd0, 32'd10, 32'd20, 1'b0);
    check("postrst_alu", alu_out, 32'd0);
    check("postrst_valid", {31'b0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
